stream_ones_zeros_counter: RTL and testbench
============================================

# stream_ones_zeros_counter

Streaming, frame-based ones/zeros counter. It accepts a sequence of WIDTH-bit words over a valid/ready handshake and accumulates per-frame ones and zeros totals. At the end of each frame it presents the totals and the word count on a registered, handshaked result port. It sits behind data-path blocks that need bit-density statistics, such as DC-balance and scrambler checks, and generalises the single-word combinational counter to multi-word frames with back-pressure.

## Interface
- `WIDTH`, 8: bits per input word; must be ≥ 1.
- `FRAME_WORDS`, 16: maximum words per frame; must be ≥ 1.
- Derived `CW` = `$clog2(WIDTH*FRAME_WORDS+1)`: width of the ones/zeros totals.
- Derived `WW` = `$clog2(FRAME_WORDS+1)`: width of the word count.
- Reset is synchronous and active-high; there is one clock.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  input word valid.
- `in_ready`  out  1  block can accept a word.
- `in_data`  in  WIDTH  input word.
- `in_last`  in  1  current word ends the frame (early termination).
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  downstream accepts result.
- `ones_total`  out  CW  ones in the frame.
- `zeros_total`  out  CW  zeros in the frame.
- `word_count`  out  WW  words in the frame (1..FRAME_WORDS).

## Operation
- A beat is accepted on any cycle with `in_valid && in_ready`.
- FSM states:
  - ACCUM: `in_ready`=1, `out_valid`=0.
  - HOLD: `in_ready`=0, `out_valid`=1.
- ACCUM, accepted beat:
  - The popcount of `in_data` is added to `ones_acc`, and `words_acc` is incremented.
  - The frame ends if `in_last`=1 or the post-increment `words_acc` equals FRAME_WORDS.
- At frame end:
  - `ones_total` ← `ones_acc` + popcount (this beat included).
  - `word_count` ← final word count.
  - `zeros_total` ← WIDTH*`word_count` − `ones_total`.
  - Accumulators clear to 0, and the FSM moves to HOLD.
- HOLD:
  - Result outputs stay stable until `out_ready`=1.
  - On that cycle the FSM moves to ACCUM, and `out_valid` drops the next cycle.
- `in_last` on the FRAME_WORDS-th word ends a single frame (no empty extra frame).
- `in_last` is ignored when `in_valid`=0. `in_data` and `in_last` are don't-care in HOLD.
- Arithmetic is exact: totals never overflow because `CW` covers WIDTH*FRAME_WORDS, and `ones_total + zeros_total == WIDTH*word_count` always holds.
- Reset mid-frame discards the partial frame. Reset in HOLD drops the pending result.

## Timing
- Reset values:
  - `in_ready`=1, `out_valid`=0.
  - `ones_total`, `zeros_total`, `word_count` = 0.
  - Accumulators = 0, state ACCUM.
  - `in_ready` becomes 1 in the first cycle after `rst` deasserts.
- Latency: `out_valid` asserts on the cycle after the last beat is accepted.
- Throughput:
  - One word per cycle within a frame.
  - Minimum one cycle of `in_ready`=0 between frames (the HOLD cycle), even with `out_ready` tied high.
- `out_ready` may be asserted before `out_valid`. It takes effect only in HOLD.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- Macro: `STREAM_ONES_ZEROS_PEAK_EN`.
- Defined:
  - Adds port `peak_ones`  out  `$clog2(WIDTH+1)`, the maximum single-word popcount within the frame.
  - `peak_ones` is loaded with the other results at frame end, holds in HOLD, and resets to 0.
  - A peak register tracks the running maximum and clears at frame end.
- Undefined: the port and its register are absent, and all other behaviour is identical.

## Test plan
WIDTH=8, FRAME_WORDS=4 unless noted.
- Full frame: words 0xFF, 0x0F, 0x01, 0x00 with `out_ready`=1 → one cycle later `ones_total`=13, `zeros_total`=19, `word_count`=4, `out_valid`=1 for exactly one cycle.
- Early termination: 0xAA then 0x03 with `in_last` → `ones_total`=6, `zeros_total`=10, `word_count`=2. A following full frame is counted from zero.
- Back-pressure: `out_ready`=0 for 5 cycles after frame end → `in_ready`=0 and outputs stable throughout. `out_ready`=1 → `out_valid` drops next cycle and `in_ready` returns to 1.
- Reset mid-frame: 2 words of 0xFF, `rst` for 1 cycle, then 4 words of 0x00 → `ones_total`=0, `zeros_total`=32, `word_count`=4.
- `in_last` on 4th word, plus gapped `in_valid` (bubbles between beats) → a single result with correct totals and no empty frame.
- With `STREAM_ONES_ZEROS_PEAK_EN`: words 0x01, 0x7F, 0x03, 0x00 → `peak_ones`=7, `ones_total`=10.

Source files
------------

// File: rtl/stream_ones_zeros_counter.sv
// stream_ones_zeros_counter: per-frame ones/zeros/word totals over a valid/ready word stream.
// Optional STREAM_ONES_ZEROS_PEAK_EN adds peak_ones, the largest single-word popcount in the frame.
module stream_ones_zeros_counter #(
    parameter int WIDTH       = 8,
    parameter int FRAME_WORDS = 16,
    parameter int CW          = $clog2(WIDTH*FRAME_WORDS+1),
    parameter int WW          = $clog2(FRAME_WORDS+1),
    parameter int PW          = $clog2(WIDTH+1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    ones_total,
    output logic [CW-1:0]    zeros_total,
    output logic [WW-1:0]    word_count
`ifdef STREAM_ONES_ZEROS_PEAK_EN
   ,output logic [PW-1:0]    peak_ones
`endif
);
    typedef enum logic {ACCUM, HOLD} state_t;
    state_t          r_state;
    logic            r_in_ready;
    logic            r_out_valid;
    logic [CW-1:0]   r_ones_total;
    logic [CW-1:0]   r_zeros_total;
    logic [WW-1:0]   r_word_count;
    logic [CW-1:0]   r_ones_acc;
    logic [WW-1:0]   r_words_acc;
    logic [PW-1:0]   w_pop;
    logic [CW-1:0]   w_ones;
    logic [WW-1:0]   w_words;
    logic [CW-1:0]   w_zeros;
    logic            w_end;
    always_comb begin
        w_pop = '0;
        for (int i = 0; i < WIDTH; i++) w_pop = w_pop + PW'(in_data[i]);
    end
    assign w_ones  = r_ones_acc + CW'(w_pop);
    assign w_words = r_words_acc + WW'(1);
    assign w_zeros = CW'(WIDTH) * CW'(w_words) - w_ones;
    assign w_end   = in_last || (w_words == WW'(FRAME_WORDS));
`ifdef STREAM_ONES_ZEROS_PEAK_EN
    logic [PW-1:0] r_peak;
    logic [PW-1:0] r_peak_ones;
    logic [PW-1:0] w_peak;
    assign w_peak    = (w_pop > r_peak) ? w_pop : r_peak;
    assign peak_ones = r_peak_ones;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_peak      <= '0;
            r_peak_ones <= '0;
        end else if (r_state == ACCUM && in_valid) begin
            r_peak      <= w_end ? '0 : w_peak;
            r_peak_ones <= w_end ? w_peak : r_peak_ones;
        end
    end
`endif
    // Result registers load only at frame end so they stay frozen through HOLD.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ACCUM;
            r_in_ready    <= 1'b1;
            r_out_valid   <= 1'b0;
            r_ones_total  <= '0;
            r_zeros_total <= '0;
            r_word_count  <= '0;
            r_ones_acc    <= '0;
            r_words_acc   <= '0;
        end else if (r_state == ACCUM) begin
            if (in_valid && w_end) begin
                r_state       <= HOLD;
                r_in_ready    <= 1'b0;
                r_out_valid   <= 1'b1;
                r_ones_total  <= w_ones;
                r_zeros_total <= w_zeros;
                r_word_count  <= w_words;
                r_ones_acc    <= '0;
                r_words_acc   <= '0;
            end else if (in_valid) begin
                r_ones_acc    <= w_ones;
                r_words_acc   <= w_words;
            end
        end else if (out_ready) begin
            r_state     <= ACCUM;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end
    end
    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign ones_total  = r_ones_total;
    assign zeros_total = r_zeros_total;
    assign word_count  = r_word_count;
endmodule

// File: tb/tb_stream_ones_zeros_counter.sv
// tb_stream_ones_zeros_counter: directed and randomized frames checked against a popcount frame model.
module tb_stream_ones_zeros_counter;
    localparam int W  = 8;
    localparam int FW = 4;
    localparam int CW = $clog2(W*FW+1);
    localparam int WW = $clog2(FW+1);
    localparam int PW = $clog2(W+1);
    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_last = 1'b0;
    logic          out_ready = 1'b0;
    logic [W-1:0]  in_data = '0;
    logic          in_ready;
    logic          out_valid;
    logic [CW-1:0] ones_total;
    logic [CW-1:0] zeros_total;
    logic [WW-1:0] word_count;
`ifdef STREAM_ONES_ZEROS_PEAK_EN
    logic [PW-1:0] peak_ones;
`endif
    int total = 0;
    int bad = 0;
    int exp_peak = 0;

    stream_ones_zeros_counter #(.WIDTH(W), .FRAME_WORDS(FW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
        .out_ready(out_ready), .ones_total(ones_total), .zeros_total(zeros_total),
        .word_count(word_count)
`ifdef STREAM_ONES_ZEROS_PEAK_EN
       ,.peak_ones(peak_ones)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [W-1:0] d, input logic l);
        int n = 0;
        while (in_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL beat_ready: in_ready=%b required 1", in_ready);
        end
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        tick();
        in_valid = 1'b0;
        in_last  = 1'($urandom);
        in_data  = W'($urandom);
        if ($countones(d) > exp_peak) exp_peak = $countones(d);
    endtask

    task automatic expect_result(input string name, input int ones, input int wc);
        int n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        total++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0 || ones_total !== CW'(ones) ||
            zeros_total !== CW'(W*wc - ones) || word_count !== WW'(wc)) begin
            bad++;
            $display("FAIL %s: valid=%b ready=%b ones=%0d zeros=%0d wc=%0d required valid=1 ready=0 ones=%0d zeros=%0d wc=%0d",
                     name, out_valid, in_ready, ones_total, zeros_total, word_count, ones, W*wc - ones, wc);
        end
`ifdef STREAM_ONES_ZEROS_PEAK_EN
        total++;
        if (peak_ones !== PW'(exp_peak)) begin
            bad++;
            $display("FAIL %s_peak: peak_ones=%0d required %0d", name, peak_ones, exp_peak);
        end
`endif
        exp_peak = 0;
    endtask

    task automatic release_result(input string name);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s_release: valid=%b ready=%b required valid=0 ready=1", name, out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || ones_total !== '0 ||
            zeros_total !== '0 || word_count !== '0) begin
            bad++;
            $display("FAIL reset: ready=%b valid=%b ones=%0d zeros=%0d wc=%0d required 1 0 0 0 0",
                     in_ready, out_valid, ones_total, zeros_total, word_count);
        end
`ifdef STREAM_ONES_ZEROS_PEAK_EN
        total++;
        if (peak_ones !== '0) begin
            bad++;
            $display("FAIL reset_peak: peak_ones=%0d required 0", peak_ones);
        end
`endif
        exp_peak = 0;
    endtask

    task automatic test_full_frame();
        out_ready = 1'b1;
        beat(8'hFF, 1'b0);
        beat(8'h0F, 1'b0);
        beat(8'h01, 1'b0);
        beat(8'h00, 1'b0);
        expect_result("full", 13, 4);
        tick();
        out_ready = 1'b0;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL full_one_cycle: valid=%b ready=%b required valid=0 ready=1", out_valid, in_ready);
        end
    endtask

    task automatic test_early_last();
        beat(8'hAA, 1'b0);
        beat(8'h03, 1'b1);
        expect_result("early", 6, 2);
        release_result("early");
        repeat (4) beat(8'h80, 1'b0);
        expect_result("after_early", 4, 4);
        release_result("after_early");
    endtask

    task automatic test_back_pressure();
        repeat (4) beat(8'h11, 1'b0);
        expect_result("bp", 8, 4);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = 8'hFF;
            tick();
            total++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || ones_total !== CW'(8) ||
                zeros_total !== CW'(24) || word_count !== WW'(4)) begin
                bad++;
                $display("FAIL bp_stable: cycle=%0d valid=%b ready=%b ones=%0d zeros=%0d wc=%0d required 1 0 8 24 4",
                         i, out_valid, in_ready, ones_total, zeros_total, word_count);
            end
        end
        in_valid = 1'b0;
        release_result("bp");
        beat(8'h01, 1'b1);
        expect_result("after_bp", 1, 1);
        release_result("after_bp");
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        beat(8'h3C, 1'b1);
        expect_result("b2b_a", 4, 1);
        total++;
        tick();
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL b2b_gap: ready=%b valid=%b required ready=1 valid=0", in_ready, out_valid);
        end
        beat(8'hF0, 1'b0);
        beat(8'h01, 1'b1);
        expect_result("b2b_b", 5, 2);
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        beat(8'hFF, 1'b0);
        beat(8'hFF, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_peak = 0;
        repeat (4) beat(8'h00, 1'b0);
        expect_result("rst_mid", 0, 4);
        release_result("rst_mid");
        beat(8'h0F, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_peak = 0;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || ones_total !== '0 || word_count !== '0) begin
            bad++;
            $display("FAIL rst_hold: valid=%b ready=%b ones=%0d wc=%0d required 0 1 0 0",
                     out_valid, in_ready, ones_total, word_count);
        end
    endtask

    task automatic test_last_on_full_gapped();
        beat(8'h07, 1'b0);
        tick();
        beat(8'h70, 1'b0);
        tick();
        tick();
        beat(8'hC0, 1'b0);
        tick();
        beat(8'h01, 1'b1);
        expect_result("last4", 9, 4);
        release_result("last4");
        repeat (4) tick();
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL last4_no_empty: out_valid=%b required 0", out_valid);
        end
    endtask

`ifdef STREAM_ONES_ZEROS_PEAK_EN
    task automatic test_peak();
        beat(8'h01, 1'b0);
        beat(8'h7F, 1'b0);
        beat(8'h03, 1'b0);
        beat(8'h00, 1'b0);
        expect_result("peak", 10, 4);
        release_result("peak");
    endtask
`endif

    task automatic test_random();
        for (int f = 0; f < 40; f++) begin
            int n = $urandom_range(1, FW);
            int ones = 0;
            for (int k = 0; k < n; k++) begin
                logic [W-1:0] d = W'($urandom);
                logic l = (k == n - 1) && (n < FW || $urandom_range(0, 1) == 1);
                if ($urandom_range(0, 2) == 0) tick();
                ones += $countones(d);
                beat(d, l);
            end
            expect_result("rand", ones, n);
            repeat ($urandom_range(0, 3)) tick();
            total++;
            if (out_valid !== 1'b1 || ones_total !== CW'(ones) || word_count !== WW'(n)) begin
                bad++;
                $display("FAIL rand_hold: valid=%b ones=%0d wc=%0d required 1 %0d %0d",
                         out_valid, ones_total, word_count, ones, n);
            end
            release_result("rand");
        end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_early_last();
        test_back_pressure();
        test_back_to_back();
        test_reset_mid_frame();
        test_last_on_full_gapped();
`ifdef STREAM_ONES_ZEROS_PEAK_EN
        test_peak();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
